// File: rtl/mdu_seq_unit.sv
// Iterative RV32M multiply/divide sequencer: 32-step shift-add multiply or
// restoring divide, with freeze/kill handling for the EX-stage pipeline.
//
//   state     | meaning
//   ----------+----------------------------------------------------
//   ST_IDLE   | waiting for start_i
//   ST_CALC   | one multiply/divide iteration per unfrozen edge
//   ST_FINISH | sign correction, result write, done pulse
module mdu_seq_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            start_i,
  input  logic            kill_i,
  input  logic            freeze_i,
  input  logic [2:0]      func3_i,
  input  logic [XLEN-1:0] operand1_i,
  input  logic [XLEN-1:0] operand2_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o,
  output logic            done_o
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CALC   = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

  logic [1:0]          state_q, state_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [2:0]          func3_q, func3_d;
  logic                neg_q, neg_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     opb_q, opb_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic                done_q, done_d;

  // Launch decode: operand signedness, magnitudes and special cases
  logic            signed1, signed2, neg1, neg2, div0, ovf;
  logic [XLEN-1:0] mag1, mag2;

  assign signed1 = (func3_i == 3'b001) || (func3_i == 3'b010) ||
                   (func3_i == 3'b100) || (func3_i == 3'b110);
  assign signed2 = (func3_i == 3'b001) || (func3_i == 3'b100) || (func3_i == 3'b110);
  assign neg1    = signed1 && operand1_i[XLEN-1];
  assign neg2    = signed2 && operand2_i[XLEN-1];
  assign mag1    = neg1 ? (~operand1_i + 1'b1) : operand1_i;
  assign mag2    = neg2 ? (~operand2_i + 1'b1) : operand2_i;
  assign div0    = func3_i[2] && (operand2_i == '0);
  assign ovf     = func3_i[2] && !func3_i[0] &&
                   (operand1_i == MIN_NEG) && (operand2_i == ALL_ONES);

  // acc_q holds {high, multiplier} for multiply and {remainder, quotient} for divide
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_rem_sh;
  logic              div_ge;
  logic [2*XLEN-1:0] div_next;

  assign mul_sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign mul_next   = {mul_sum, acc_q[XLEN-1:1]};
  assign div_rem_sh = acc_q[2*XLEN-1:XLEN-1];
  assign div_ge     = (div_rem_sh >= {1'b0, opb_q});
  assign div_next   = {div_ge ? (div_rem_sh[XLEN-1:0] - opb_q) : div_rem_sh[XLEN-1:0],
                       acc_q[XLEN-2:0], div_ge};

  logic [2*XLEN-1:0] prod_fin;
  logic [XLEN-1:0]   quo_fin, rem_fin, fin_result;

  assign prod_fin = neg_q ? (~acc_q + 1'b1) : acc_q;
  assign quo_fin  = neg_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
  assign rem_fin  = neg_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];

  always_comb begin
    fin_result = '0;
    if (!func3_q[2]) begin
      fin_result = (func3_q[1:0] == 2'b00) ? prod_fin[XLEN-1:0] : prod_fin[2*XLEN-1:XLEN];
    end else begin
      fin_result = func3_q[1] ? rem_fin : quo_fin;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    func3_d  = func3_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    result_d = result_q;
    done_d   = 1'b0;
    if (kill_i) begin
      state_d = ST_IDLE;
    end else if (!freeze_i) begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            func3_d = func3_i;
            cnt_d   = '0;
            opb_d   = mag2;
            neg_d   = (func3_i == 3'b110) ? neg1 : (neg1 ^ neg2);
            if (div0) begin
              // preload {remainder, quotient} with the architectural div-by-zero answers
              acc_d   = {operand1_i, ALL_ONES};
              neg_d   = 1'b0;
              state_d = ST_FINISH;
            end else if (ovf) begin
              acc_d   = {{XLEN{1'b0}}, MIN_NEG};
              neg_d   = 1'b0;
              state_d = ST_FINISH;
            end else begin
              acc_d   = {{XLEN{1'b0}}, mag1};
              state_d = ST_CALC;
            end
          end
        end
        ST_CALC: begin
          acc_d = func3_q[2] ? div_next : mul_next;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d = ST_FINISH;
          end
        end
        ST_FINISH: begin
          result_d = fin_result;
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      func3_q  <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      func3_q  <= func3_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign result_o = result_q;
  assign busy_o   = (state_q != ST_IDLE);
  assign done_o   = done_q;

endmodule

// File: tb/tb_mdu_seq_unit.sv
// Self-checking bench for mdu_seq_unit: directed corner cases, freeze/kill/reset
// scenarios and randomized operations against an arithmetic reference model.
module tb_mdu_seq_unit;

  logic        clk, rst_n, start, kill, freeze;
  logic [2:0]  func3;
  logic [31:0] op1, op2, result;
  logic        busy, done;

  int vectors = 0;
  int errors  = 0;

  mdu_seq_unit #(.XLEN(32)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .start_i    (start),
    .kill_i     (kill),
    .freeze_i   (freeze),
    .func3_i    (func3),
    .operand1_i (op1),
    .operand2_i (op2),
    .result_o   (result),
    .busy_o     (busy),
    .done_o     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub;
    logic [63:0] p;
    int ia, ib;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    ia = a;
    ib = b;
    p  = '0;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a,
                                     input logic [31:0] b);
    if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      return 2;
    return 34;
  endfunction

  // Called at a falling edge; launches one op and returns at the falling edge where done is seen.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int busy_cyc);
    start = 1'b1;
    func3 = f;
    op1   = a;
    op2   = b;
    lat      = 0;
    busy_cyc = 0;
    while (lat < 200) begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (busy) busy_cyc++;
      if (done) break;
    end
    res = result;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; kill = 1'b0; freeze = 1'b0;
    func3 = '0; op1 = '0; op2 = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if (result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h expected 00000000", result); end
    vectors++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vectors++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [2:0]  t_f [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6};
    logic [31:0] t_a [12] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                              32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000,
                              32'h8000_0000};
    logic [31:0] t_b [12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd2,
                              32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] t_e [12] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                              32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5,
                              32'h8000_0000, 32'd0};
    int          t_l [12] = '{34, 34, 34, 34, 34, 34, 34, 34, 2, 2, 2, 2};
    logic [31:0] res;
    int lat, bc;
    for (int i = 0; i < 12; i++) begin
      run_op(t_f[i], t_a[i], t_b[i], res, lat, bc);
      vectors++;
      if (res !== t_e[i]) begin
        errors++; $display("FAIL directed_%0d_result: got %h expected %h", i, res, t_e[i]);
      end
      vectors++;
      if (lat !== t_l[i]) begin
        errors++; $display("FAIL directed_%0d_latency: got %0d expected %0d", i, lat, t_l[i]);
      end
      vectors++;
      if (bc !== t_l[i] - 1) begin
        errors++; $display("FAIL directed_%0d_busy: got %0d expected %0d", i, bc, t_l[i] - 1);
      end
    end
  endtask

  task automatic test_freeze();
    logic [2:0]  c_f  [2] = '{3'd0, 3'd5};
    logic [31:0] c_a  [2] = '{32'd3, 32'd100};
    logic [31:0] c_b  [2] = '{32'd5, 32'd7};
    logic [31:0] c_e  [2] = '{32'd15, 32'd14};
    int          c_at [2] = '{10, 33};
    int          c_len[2] = '{5, 2};
    int lat;
    logic early_done;
    for (int c = 0; c < 2; c++) begin
      start = 1'b1; func3 = c_f[c]; op1 = c_a[c]; op2 = c_b[c];
      lat = 0; early_done = 1'b0;
      while (lat < 200) begin
        @(negedge clk);
        start = 1'b0;
        lat++;
        if (done && freeze) early_done = 1'b1;
        if (lat == c_at[c]) freeze = 1'b1;
        if (lat == c_at[c] + c_len[c]) freeze = 1'b0;
        if (done) break;
      end
      freeze = 1'b0;
      vectors++;
      if (result !== c_e[c]) begin
        errors++; $display("FAIL freeze_%0d_result: got %h expected %h", c, result, c_e[c]);
      end
      vectors++;
      if (lat !== 34 + c_len[c]) begin
        errors++; $display("FAIL freeze_%0d_latency: got %0d expected %0d", c, lat, 34 + c_len[c]);
      end
      vectors++;
      if (early_done !== 1'b0) begin
        errors++; $display("FAIL freeze_%0d_done_while_frozen: got %b expected 0", c, early_done);
      end
    end
  endtask

  task automatic test_kill();
    logic [31:0] res, prior, exp;
    int lat, bc;
    logic saw_done;
    run_op(3'd5, 32'd100, 32'd7, prior, lat, bc);
    vectors++;
    if (prior !== 32'd14) begin errors++; $display("FAIL kill_prior_result: got %h expected 0000000e", prior); end
    start = 1'b1; func3 = 3'd4; op1 = 32'hFFFF_FF00; op2 = 32'd3;
    saw_done = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) saw_done = 1'b1;
    end
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    if (done) saw_done = 1'b1;
    vectors++;
    if (busy !== 1'b0) begin errors++; $display("FAIL kill_busy: got %b expected 0", busy); end
    vectors++;
    if (saw_done !== 1'b0) begin errors++; $display("FAIL kill_done: got %b expected 0", saw_done); end
    vectors++;
    if (result !== prior) begin errors++; $display("FAIL kill_result_hold: got %h expected %h", result, prior); end
    exp = ref_model(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat, bc);
    vectors++;
    if (res !== exp) begin errors++; $display("FAIL kill_relaunch_result: got %h expected %h", res, exp); end
    vectors++;
    if (lat !== 34) begin errors++; $display("FAIL kill_relaunch_latency: got %0d expected 34", lat); end
  endtask

  task automatic test_start_blocked();
    logic [31:0] res;
    int lat, bc;
    start = 1'b1; kill = 1'b1; func3 = 3'd0; op1 = 32'd9; op2 = 32'd9;
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin errors++; $display("FAIL start_with_kill_busy: got %b expected 0", busy); end
    start = 1'b1; freeze = 1'b1;
    @(negedge clk);
    start = 1'b0; freeze = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin errors++; $display("FAIL start_with_freeze_busy: got %b expected 0", busy); end
    // restart request mid-operation with different operands must not disturb the running op
    start = 1'b1; func3 = 3'd0; op1 = 32'd6; op2 = 32'd7;
    lat = 0;
    while (lat < 200) begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (lat == 5) begin start = 1'b1; func3 = 3'd5; op1 = 32'd1; op2 = 32'd0; end
      if (done) break;
    end
    vectors++;
    if (result !== 32'd42) begin errors++; $display("FAIL start_while_busy_result: got %h expected 0000002a", result); end
    vectors++;
    if (lat !== 34) begin errors++; $display("FAIL start_while_busy_latency: got %0d expected 34", lat); end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin errors++; $display("FAIL start_while_busy_relaunch: got %b expected 0", busy); end
    res = result;
    run_op(3'd6, 32'hFFFF_FFF9, 32'd0, res, lat, bc);
    vectors++;
    if (res !== 32'hFFFF_FFF9) begin errors++; $display("FAIL rem_div0_negative: got %h expected fffffff9", res); end
  endtask

  task automatic test_random();
    logic [2:0]  f;
    logic [31:0] a, b, res, exp;
    int lat, bc, elat, mode;
    for (int i = 0; i < 60; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      mode = $urandom_range(0, 9);
      if (mode == 0) b = 32'd0;
      if (mode == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      if (mode == 2) b = $urandom_range(1, 15);
      if (mode == 3) a = $urandom_range(0, 300);
      if (mode == 4) b = 32'hFFFF_FFFF - $urandom_range(0, 9);
      exp  = ref_model(f, a, b);
      elat = ref_latency(f, a, b);
      run_op(f, a, b, res, lat, bc);
      vectors++;
      if (res !== exp) begin
        errors++; $display("FAIL random_%0d_result f=%0d a=%h b=%h: got %h expected %h", i, f, a, b, res, exp);
      end
      vectors++;
      if (lat !== elat) begin
        errors++; $display("FAIL random_%0d_latency: got %0d expected %0d", i, lat, elat);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res;
    int lat, bc, gap;
    run_op(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, res, lat, bc);
    vectors++;
    if (res !== ref_model(3'd1, 32'h1234_5678, 32'h9ABC_DEF0)) begin
      errors++; $display("FAIL b2b_first_result: got %h expected %h", res, ref_model(3'd1, 32'h1234_5678, 32'h9ABC_DEF0));
    end
    run_op(3'd7, 32'hDEAD_BEEF, 32'd1000, res, lat, bc);
    vectors++;
    if (res !== 32'hDEAD_BEEF % 32'd1000) begin
      errors++; $display("FAIL b2b_second_result: got %h expected %h", res, 32'hDEAD_BEEF % 32'd1000);
    end
    vectors++;
    if (lat !== 34) begin errors++; $display("FAIL b2b_second_latency: got %0d expected 34", lat); end
    gap = 0;
    @(negedge clk);
    if (done) gap = 1;
    vectors++;
    if (gap !== 0) begin errors++; $display("FAIL b2b_done_width: got %0d expected 0", gap); end
  endtask

  task automatic test_async_reset();
    logic [31:0] res;
    int lat, bc;
    start = 1'b1; func3 = 3'd0; op1 = 32'd123; op2 = 32'd456;
    repeat (12) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (result !== 32'd0) begin errors++; $display("FAIL async_reset_result: got %h expected 00000000", result); end
    vectors++;
    if (busy !== 1'b0) begin errors++; $display("FAIL async_reset_busy: got %b expected 0", busy); end
    vectors++;
    if (done !== 1'b0) begin errors++; $display("FAIL async_reset_done: got %b expected 0", done); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(3'd2, 32'h8000_0001, 32'hFFFF_FFFF, res, lat, bc);
    vectors++;
    if (res !== ref_model(3'd2, 32'h8000_0001, 32'hFFFF_FFFF)) begin
      errors++; $display("FAIL post_reset_result: got %h expected %h", res, ref_model(3'd2, 32'h8000_0001, 32'hFFFF_FFFF));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_freeze();
    test_kill();
    test_start_blocked();
    test_random();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
